// File: rtl/msg_tx_pkg.sv
// msg_tx_pkg: shared types and constants for the message transmit scheduler.
//   state_t      FSM encoding (IDLE, ARM, WAIT_DONE, CLEAR)
//   msg_t        16-byte message buffer, byte i at bits [8i+7:8i]
//   MSG_CHARS    buffer depth in characters
//   ASCII_*      character codes recognised by the editor
package msg_tx_pkg;

    localparam int MSG_CHARS = 16;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_MAX   = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_DONE,
        CLEAR
    } state_t;

    typedef logic [MSG_CHARS-1:0][7:0] msg_t;

    localparam msg_t MSG_BLANK = {MSG_CHARS{ASCII_SPACE}};

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_MAX);
    endfunction

endpackage

// File: rtl/msg_tx_scheduler_sync_rise.sv
// sync_rise: two-flop synchronizer with a registered rising-edge pulse.
//   clock    destination clock
//   resetn   async active-low reset, clears all flops
//   async_in signal from a foreign clock domain
//   rise     one-cycle pulse, high in the first cycle the synchronized
//            level (s2) reads 1
module sync_rise (
    input  logic clock,
    input  logic resetn,
    input  logic async_in,
    output logic rise
);

    logic s1, s2;

    // rise(t+1) = s1(t) & ~s2(t) = s2(t+1) & ~s2(t): the registered edge of
    // the synchronized level, aligned with the cycle s2 first goes high.
    // s1 has had a full cycle to resolve before it reaches the pulse flop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            rise <= s1 & ~s2;
        end
    end

endmodule

// File: rtl/msg_tx_scheduler.sv
// msg_tx_scheduler: keyboard line editor plus hand-off of a frozen 16-char
// message to a slow-clock link.
//   clock, resetn      clock; async active-low reset
//   char_valid/char_in keyboard strobe (acted on at its rising edge) and ASCII code
//   send_req           level request to transmit (Enter does the same)
//   tx_done            async done flag from the link
//   data_ready         message available to the link
//   tx_message         frozen message under transmission
//   edit_message       live edit buffer
//   char_count         characters in the buffer, 0..16
//   busy               FSM not in IDLE
//   overflow           sticky: printable char dropped on a full buffer
//   tx_err             sticky: link did not answer in time
// Optional feature: define MSG_TX_TIMEOUT_EN to abort WAIT_DONE after
// TIMEOUT_CYCLES cycles; otherwise WAIT_DONE waits forever and tx_err is 0.
import msg_tx_pkg::*;

module msg_tx_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         char_valid,
    input  logic [7:0]   char_in,
    input  logic         send_req,
    input  logic         tx_done,
    output logic         data_ready,
    output logic [127:0] tx_message,
    output logic [127:0] edit_message,
    output logic [4:0]   char_count,
    output logic         busy,
    output logic         overflow,
    output logic         tx_err
);

    state_t state, state_nxt;
    msg_t   edit_buf, tx_buf;
    logic   char_q, char_rise, in_idle;
    logic   do_add, do_drop, do_bs, send_any;
    logic   done_rise, timeout_hit;
    logic [4:0] count_upd;
    logic [3:0] bs_idx;

    sync_rise u_done_sync (
        .clock    (clock),
        .resetn   (resetn),
        .async_in (tx_done),
        .rise     (done_rise)
    );

    assign char_rise = char_valid & ~char_q;
    assign in_idle   = (state == IDLE);
    assign do_add    = in_idle & char_rise & is_printable(char_in) & (char_count <  5'(MSG_CHARS));
    assign do_drop   = in_idle & char_rise & is_printable(char_in) & (char_count == 5'(MSG_CHARS));
    assign do_bs     = in_idle & char_rise & (char_in == ASCII_BS) & (char_count != 5'd0);
    assign send_any  = send_req | (char_rise & (char_in == ASCII_CR));
    assign bs_idx    = char_count[3:0] - 4'd1;  // count 16 wraps to byte 15

    // Count after this cycle's edit, so a char arriving with the send request
    // counts toward "buffer not empty" and lands in the ARM snapshot.
    always_comb begin
        count_upd = char_count;
        if (do_add)
            count_upd = char_count + 5'd1;
        else if (do_bs)
            count_upd = char_count - 5'd1;
    end

`ifdef MSG_TX_TIMEOUT_EN
    logic [31:0] to_cnt;

    // done takes priority if both fire in the same cycle
    assign timeout_hit = (state == WAIT_DONE) && !done_rise &&
                         (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
            tx_err <= 1'b0;
        end else begin
            if (state == ARM)
                to_cnt <= '0;
            else if (state == WAIT_DONE)
                to_cnt <= to_cnt + 32'd1;
            if (timeout_hit)
                tx_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
    assign tx_err      = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (send_any && (count_upd != 5'd0)) state_nxt = ARM;
            ARM:       state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_rise)        state_nxt = CLEAR;
                       else if (timeout_hit) state_nxt = IDLE;
            CLEAR:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            char_q     <= 1'b0;
            edit_buf   <= MSG_BLANK;
            tx_buf     <= MSG_BLANK;
            char_count <= 5'd0;
            data_ready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            char_q     <= char_valid;
            char_count <= count_upd;
            if (do_add)
                edit_buf[char_count[3:0]] <= char_in;
            if (do_bs)
                edit_buf[bs_idx] <= ASCII_SPACE;
            if (do_drop)
                overflow <= 1'b1;
            case (state)
                ARM: begin
                    tx_buf     <= edit_buf;
                    data_ready <= 1'b1;
                end
                // Dropping here (not in CLEAR) puts the fall on the third
                // edge after tx_done rises.
                WAIT_DONE: if (done_rise || timeout_hit) data_ready <= 1'b0;
                CLEAR: begin
                    data_ready <= 1'b0;
                    edit_buf   <= MSG_BLANK;
                    char_count <= 5'd0;
                end
                default: ;
            endcase
        end
    end

    assign edit_message = edit_buf;
    assign tx_message   = tx_buf;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Scoreboard bench for msg_tx_scheduler. Stimulus pushes expected state
// snapshots and expected transmitted messages into queues; monitors pop and
// compare on the falling edge. Build with +define+MSG_TX_TIMEOUT_EN to add
// the timeout scenario (DUT built with TIMEOUT_CYCLES=100).
module tb_msg_tx_scheduler;

    localparam logic [127:0] SP = {16{8'h20}};

    typedef struct {
        string        name;
        logic [4:0]   cnt;
        logic         ov, busy, dr, err;
        logic [127:0] edit, tx;
    } snap_t;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         char_valid = 1'b0;
    logic [7:0]   char_in = 8'h00;
    logic         send_req = 1'b0;
    logic         tx_done = 1'b0;
    logic         data_ready;
    logic [127:0] tx_message, edit_message;
    logic [4:0]   char_count;
    logic         busy, overflow, tx_err;

    msg_tx_scheduler #(.TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .resetn(resetn), .char_valid(char_valid), .char_in(char_in),
        .send_req(send_req), .tx_done(tx_done), .data_ready(data_ready),
        .tx_message(tx_message), .edit_message(edit_message), .char_count(char_count),
        .busy(busy), .overflow(overflow), .tx_err(tx_err)
    );

    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_errs   = 0;
    logic         chk = 1'b0;
    snap_t        exp_q[$];
    logic [127:0] tx_q[$];
    logic         m_ov = 1'b0, m_err = 1'b0;
    logic [127:0] m_tx = SP;

    function automatic logic [127:0] msg(input string s);
        logic [127:0] r;
        r = SP;
        for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the current cycle's outputs, then advance one edge.
    task automatic snap(input string name, input int cnt, input logic b,
                        input logic dr, input string ed);
        snap_t e;
        e.name = name; e.cnt = 5'(cnt); e.ov = m_ov; e.busy = b; e.dr = dr;
        e.err = m_err; e.edit = msg(ed); e.tx = m_tx;
        exp_q.push_back(e);
        chk = 1'b1;
        tick();
        chk = 1'b0;
    endtask

    task automatic type_char(input logic [7:0] c);
        char_valid = 1'b1; char_in = c;
        tick();
        char_valid = 1'b0;
        tick();
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) type_char(s[i]);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Snapshot monitor
    initial begin
        snap_t e;
        forever begin
            @(negedge clock);
            if (chk) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errs++;
                    $display("FAIL snap_queue: got check strobe, expected a queued snapshot");
                end else begin
                    e = exp_q.pop_front();
                    if (char_count !== e.cnt || overflow !== e.ov || busy !== e.busy ||
                        data_ready !== e.dr || tx_err !== e.err ||
                        edit_message !== e.edit || tx_message !== e.tx) begin
                        n_errs++;
                        $display("FAIL %s: got cnt=%0d ov=%b busy=%b dr=%b err=%b edit=%h tx=%h, expected cnt=%0d ov=%b busy=%b dr=%b err=%b edit=%h tx=%h",
                                 e.name, char_count, overflow, busy, data_ready, tx_err, edit_message, tx_message,
                                 e.cnt, e.ov, e.busy, e.dr, e.err, e.edit, e.tx);
                    end
                end
            end
        end
    end

    // Transmission monitor: every data_ready rise must match a queued message
    initial begin
        logic         dr_prev;
        logic [127:0] exp;
        dr_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (data_ready === 1'b1 && !dr_prev) begin
                n_checks++;
                if (tx_q.size() == 0) begin
                    n_errs++;
                    $display("FAIL tx_unexpected: got data_ready rise with tx=%h, expected none", tx_message);
                end else begin
                    exp = tx_q.pop_front();
                    if (tx_message !== exp) begin
                        n_errs++;
                        $display("FAIL tx_message: got %h, expected %h", tx_message, exp);
                    end
                end
            end
            dr_prev = (data_ready === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset values while resetn is held low
        tick(); tick();
        snap("reset", 0, 0, 0, "");
        resetn = 1'b1;
        tick();

        // 'H','i'
        type_str("Hi");
        snap("hi", 2, 0, 0, "Hi");
        type_char(8'h08); type_char(8'h08);
        snap("hi_erased", 0, 0, 0, "");

        // 'A', BS, BS (second BS on empty buffer is ignored); non-printable ignored
        type_char("A"); type_char(8'h08); type_char(8'h08); type_char(8'h01);
        snap("a_bs_bs", 0, 0, 0, "");

        // send request on empty buffer stays IDLE
        send_req = 1'b1; tick(); send_req = 1'b0;
        snap("empty_send", 0, 0, 0, "");

        // 'A' then Enter
        type_char("A");
        tx_q.push_back(msg("A"));
        char_valid = 1'b1; char_in = 8'h0D;
        tick();
        char_valid = 1'b0;
        snap("enter_arm", 1, 1, 0, "A");
        m_tx = msg("A");
        snap("enter_wait", 1, 1, 1, "A");
        tx_done = 1'b1;
        tick(); tick();
        snap("done_edge2", 1, 1, 1, "A");
        snap("done_edge3", 1, 1, 0, "A");
        snap("cleared", 0, 0, 0, "");
        tx_done = 1'b0;
        tick(); tick();

        // char and send_req together: char lands in the snapshot
        char_valid = 1'b1; char_in = "Z"; send_req = 1'b1;
        tx_q.push_back(msg("Z"));
        tick();
        char_valid = 1'b0; send_req = 1'b0;
        snap("co_arm", 1, 1, 0, "Z");
        m_tx = msg("Z");
        snap("co_wait", 1, 1, 1, "Z");
        type_char("Q");
        snap("busy_drop", 1, 1, 1, "Z");
        tx_done = 1'b1;
        tick(); tick(); tick(); tick();
        tx_done = 1'b0;
        snap("co_idle", 0, 0, 0, "");

        // overflow: 16 fit, 17th dropped
        type_str("ABCDEFGHIJKLMNOP");
        snap("full16", 16, 0, 0, "ABCDEFGHIJKLMNOP");
        type_char("Q");
        m_ov = 1'b1;
        snap("overflow", 16, 0, 0, "ABCDEFGHIJKLMNOP");

        resetn = 1'b0; tick();
        m_ov = 1'b0; m_tx = SP;
        snap("reset2", 0, 0, 0, "");
        resetn = 1'b1; tick();

`ifdef MSG_TX_TIMEOUT_EN
        type_str("AB");
        tx_q.push_back(msg("AB"));
        char_valid = 1'b1; char_in = 8'h0D;
        tick();
        char_valid = 1'b0;
        tick();
        m_tx = msg("AB");
        n = 0;
        while (tx_err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_int("timeout_cycles", n, 100);
        m_err = 1'b1;
        snap("timeout", 2, 0, 0, "AB");
        resetn = 1'b0; tick();
        m_err = 1'b0; m_tx = SP;
        resetn = 1'b1; tick();
`endif

        // reset in WAIT_DONE abandons the transfer
        type_char("C");
        tx_q.push_back(msg("C"));
        char_valid = 1'b1; char_in = 8'h0D;
        tick();
        char_valid = 1'b0;
        tick(); tick(); tick();
        resetn = 1'b0;
        #1;
        m_tx = SP;
        snap("reset_wait", 0, 0, 0, "");
        resetn = 1'b1;
        tx_done = 1'b1;
        tick(); tick(); tick(); tick();
        tx_done = 1'b0;
        snap("after_reset", 0, 0, 0, "");
        tick(); tick();

        check_int("tx_pending", tx_q.size(), 0);
        check_int("snap_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
